// File: rtl/sprite_motion_pkg.sv
// Shared types and screen geometry for the sprite motion controller.
package sprite_motion_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;

    typedef enum logic [1:0] {
        TICK_WAIT,
        TICK_CALC,
        TICK_COMMIT
    } tick_state_t;

    typedef enum logic {
        VERT_GROUND,
        VERT_AIRBORNE
    } vert_state_t;

endpackage

// File: rtl/vga_frame_tick.sv
// Once-per-frame tick: rising edge of the (iVGA_Y == UPDATE_LINE, iVGA_X == 0) match,
// so a stalled scan position cannot retrigger the update.
module vga_frame_tick #(
    parameter int UPDATE_LINE = 481
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [sprite_motion_pkg::X_W-1:0]  iVGA_X,
    input  logic [sprite_motion_pkg::Y_W-1:0]  iVGA_Y,
    output logic                               tick
);
    import sprite_motion_pkg::*;

    localparam logic [Y_W-1:0] LINE = Y_W'(UPDATE_LINE);

    logic hit;
    logic hit_q;

    assign hit  = (iVGA_Y == LINE) && (iVGA_X == '0);
    assign tick = hit && !hit_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit;
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position update (bounce + gravity jump), committed during vertical blanking.
// Define SPRITE_MOTION_WRAP_EN to wrap horizontally instead of bouncing.
module sprite_motion_ctrl #(
    parameter int SCREEN_W    = sprite_motion_pkg::SCREEN_W,
    parameter int SPRITE_W    = 120,
    parameter int INIT_X      = 100,
    parameter int INIT_Y      = 40,
    parameter int VEL_X       = 2,
    parameter int JUMP_V      = 12,
    parameter int GRAVITY     = 1,
    parameter int UPDATE_LINE = 481
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               motion_en,
    input  logic                               iJump,
    input  logic [sprite_motion_pkg::X_W-1:0]  iVGA_X,
    input  logic [sprite_motion_pkg::Y_W-1:0]  iVGA_Y,
    output logic [sprite_motion_pkg::X_W-1:0]  current_topLeft_X,
    output logic [sprite_motion_pkg::Y_W-1:0]  current_topLeft_Y,
    output logic                               oAirborne,
    output logic                               oFrameDone
);
    import sprite_motion_pkg::*;

    localparam logic signed [10:0] XMAX     = 11'(SCREEN_W - SPRITE_W);
    localparam logic signed [10:0] VX       = 11'(VEL_X);
    localparam logic signed [10:0] Y_GROUND = 11'(INIT_Y);
    localparam logic signed [9:0]  VY_JUMP  = 10'(-JUMP_V);
    localparam logic signed [9:0]  VY_G     = 10'(GRAVITY);

    tick_state_t        tick_state;
    vert_state_t        vstate;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic signed [9:0]  vy_q;
    logic               dir_left;
    logic               jump_latch;
    logic               en_q;
    logic               frame_done;
    logic               tick;

    logic signed [10:0] nx;
    logic signed [10:0] ny;
    logic signed [9:0]  vy_eff;
    logic               take;
    logic [X_W-1:0]     x_n;
    logic [Y_W-1:0]     y_n;
    logic signed [9:0]  vy_n;
    logic               dir_n;
    vert_state_t        vs_n;

    vga_frame_tick #(
        .UPDATE_LINE (UPDATE_LINE)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .iVGA_X (iVGA_X),
        .iVGA_Y (iVGA_Y),
        .tick   (tick)
    );

    always_comb begin
        nx    = $signed({1'b0, x_q}) + (dir_left ? -VX : VX);
        x_n   = X_W'(nx);
        dir_n = dir_left;
`ifdef SPRITE_MOTION_WRAP_EN
        if (nx > XMAX) begin
            x_n = X_W'(nx - XMAX - 11'sd1);
        end else if (nx[10]) begin
            x_n = X_W'(XMAX + 11'sd1 + nx);
        end
`else
        if (nx > XMAX) begin
            x_n   = X_W'(XMAX);
            dir_n = 1'b1;
        end else if (nx[10]) begin
            x_n   = '0;
            dir_n = 1'b0;
        end
`endif

        // A launch applies its first displacement in the same update.
        take   = (vstate == VERT_GROUND) && jump_latch;
        vy_eff = take ? VY_JUMP : vy_q;
        ny     = $signed({2'b00, y_q}) + {vy_eff[9], vy_eff};
        y_n    = y_q;
        vy_n   = vy_q;
        vs_n   = vstate;
        if (take || (vstate == VERT_AIRBORNE)) begin
            vs_n = VERT_AIRBORNE;
            vy_n = vy_eff + VY_G;
            if (ny >= Y_GROUND) begin
                y_n  = Y_W'(INIT_Y);
                vy_n = '0;
                vs_n = VERT_GROUND;
            end else if (ny[10]) begin
                y_n  = '0;
                vy_n = '0;
            end else begin
                y_n = Y_W'(ny);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_state <= TICK_WAIT;
            vstate     <= VERT_GROUND;
            x_q        <= X_W'(INIT_X);
            y_q        <= Y_W'(INIT_Y);
            vy_q       <= '0;
            dir_left   <= 1'b0;
            jump_latch <= 1'b0;
            en_q       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if ((vstate == VERT_GROUND) && iJump) begin
                jump_latch <= 1'b1;
            end
            frame_done <= 1'b0;
            case (tick_state)
                TICK_WAIT: begin
                    if (tick) begin
                        tick_state <= TICK_CALC;
                        en_q       <= motion_en;
                    end
                end
                TICK_CALC: begin
                    tick_state <= TICK_COMMIT;
                    frame_done <= 1'b1;
                    if (en_q) begin
                        x_q      <= x_n;
                        dir_left <= dir_n;
                        y_q      <= y_n;
                        vy_q     <= vy_n;
                        vstate   <= vs_n;
                        if (take) begin
                            jump_latch <= 1'b0;
                        end
                    end
                end
                TICK_COMMIT: tick_state <= TICK_WAIT;
                default:     tick_state <= TICK_WAIT;
            endcase
        end
    end

    assign current_topLeft_X = x_q;
    assign current_topLeft_Y = y_q;
    assign oAirborne         = (vstate == VERT_AIRBORNE);
    assign oFrameDone        = frame_done;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Randomized bench for sprite_motion_ctrl with a frame-level reference model.
module tb_sprite_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       motion_en = 1'b1;
    logic       iJump = 1'b0;
    logic [9:0] iVGA_X = '0;
    logic [8:0] iVGA_Y = '0;
    logic [9:0] current_topLeft_X;
    logic [8:0] current_topLeft_Y;
    logic       oAirborne;
    logic       oFrameDone;

    always #5 clk = ~clk;

    sprite_motion_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .motion_en         (motion_en),
        .iJump             (iJump),
        .iVGA_X            (iVGA_X),
        .iVGA_Y            (iVGA_Y),
        .current_topLeft_X (current_topLeft_X),
        .current_topLeft_Y (current_topLeft_Y),
        .oAirborne         (oAirborne),
        .oFrameDone        (oFrameDone)
    );

    int errors = 0;
    int checks = 0;
    int jump_rate = 0;
    bit cmp_on = 1'b0;

    // Reference model: committed position, velocity, jump latch, frame phase.
    int m_x, m_y, m_vy, m_phase;
    bit m_left, m_air, m_latch, m_done, m_prev_hit, m_en;
    bit hit_now, latch_nx;
    int nx, ny;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_frame();
        if (!m_air && m_latch) begin
            m_vy = -12;
            m_air = 1'b1;
            latch_nx = 1'b0;
        end
        nx = m_x + (m_left ? -2 : 2);
`ifdef SPRITE_MOTION_WRAP_EN
        if (nx > 520) m_x = nx - 521;
        else if (nx < 0) m_x = 521 + nx;
        else m_x = nx;
`else
        if (nx > 520) begin m_x = 520; m_left = 1'b1; end
        else if (nx < 0) begin m_x = 0; m_left = 1'b0; end
        else m_x = nx;
`endif
        if (m_air) begin
            ny = m_y + m_vy;
            m_vy = m_vy + 1;
            if (ny >= 40) begin m_y = 40; m_vy = 0; m_air = 1'b0; end
            else if (ny < 0) begin m_y = 0; m_vy = 0; end
            else m_y = ny;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_x = 100; m_y = 40; m_vy = 0; m_phase = 0;
                m_left = 0; m_air = 0; m_latch = 0; m_done = 0; m_prev_hit = 0; m_en = 0;
            end else begin
                hit_now  = (iVGA_Y == 9'd481) && (iVGA_X == 10'd0);
                latch_nx = m_latch | (iJump && !m_air);
                m_done   = 1'b0;
                if (m_phase == 0) begin
                    if (hit_now && !m_prev_hit) begin m_phase = 1; m_en = motion_en; end
                end else if (m_phase == 1) begin
                    m_done = 1'b1;
                    m_phase = 2;
                    if (m_en) model_frame();
                end else begin
                    m_phase = 0;
                end
                m_prev_hit = hit_now;
                m_latch = latch_nx;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on && !reset) begin
                check("cmp_x", 32'(current_topLeft_X), 32'(m_x));
                check("cmp_y", 32'(current_topLeft_Y), 32'(m_y));
                check("cmp_air", 32'(oAirborne), 32'(m_air));
                check("cmp_done", 32'(oFrameDone), 32'(m_done));
            end
        end
    end

    task automatic set_idle();
        case ($urandom_range(0, 2))
            0: begin iVGA_X = 10'($urandom_range(1, 639)); iVGA_Y = 9'd481; end
            1: begin iVGA_X = 10'd0; iVGA_Y = 9'($urandom_range(0, 480)); end
            default: begin iVGA_X = 10'($urandom_range(0, 799)); iVGA_Y = 9'($urandom_range(0, 480)); end
        endcase
        iJump = (jump_rate > 0) && ($urandom_range(0, 99) < jump_rate);
    endtask

    task automatic run_frame(input int stall, input bit jmp_tick, output int done_cnt, output int done_idx);
        repeat (2) begin set_idle(); @(negedge clk); end
        done_cnt = 0;
        done_idx = -1;
        for (int k = 0; k < stall + 4; k++) begin
            if (k < stall) begin
                iVGA_X = 10'd0;
                iVGA_Y = 9'd481;
                iJump = (k == 0) ? jmp_tick : ((jump_rate > 0) && ($urandom_range(0, 99) < jump_rate));
            end else begin
                set_idle();
            end
            @(negedge clk);
            if (oFrameDone) begin
                done_cnt++;
                if (done_idx < 0) done_idx = k + 1;
            end
        end
        iJump = 1'b0;
    endtask

    int dc, di, xs;
    int exp_jump[9] = '{28, 17, 7, 0, 0, 1, 3, 6, 10};

    initial begin
        repeat (3) @(negedge clk);
        check("rst_x", 32'(current_topLeft_X), 32'd100);
        check("rst_y", 32'(current_topLeft_Y), 32'd40);
        check("rst_air", 32'(oAirborne), 32'd0);
        check("rst_done", 32'(oFrameDone), 32'd0);
        reset = 1'b0;
        cmp_on = 1'b1;

        for (int i = 0; i < 3; i++) begin
            run_frame(1, 1'b0, dc, di);
            check("walk_x", 32'(current_topLeft_X), 32'(102 + 2 * i));
            check("walk_y", 32'(current_topLeft_Y), 32'd40);
            check("done_latency", 32'(di), 32'd2);
            check("done_count", 32'(dc), 32'd1);
        end

        jump_rate = 5;
        for (int i = 0; i < 176; i++) run_frame(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), dc, di);
        jump_rate = 0;
        for (int i = 0; i < 30; i++) run_frame(int'($urandom_range(1, 3)), 1'b0, dc, di);
        check("edge_pre_x", 32'(current_topLeft_X), 32'd518);
        check("edge_pre_air", 32'(oAirborne), 32'd0);
        run_frame(1, 1'b0, dc, di);
        check("edge_x1", 32'(current_topLeft_X), 32'd520);
        run_frame(1, 1'b0, dc, di);
`ifdef SPRITE_MOTION_WRAP_EN
        check("wrap_x2", 32'(current_topLeft_X), 32'd1);
        run_frame(1, 1'b0, dc, di);
        check("wrap_x3", 32'(current_topLeft_X), 32'd3);
`else
        check("bounce_x2", 32'(current_topLeft_X), 32'd520);
        run_frame(1, 1'b0, dc, di);
        check("bounce_x3", 32'(current_topLeft_X), 32'd518);
`endif

        iVGA_X = 10'd5; iVGA_Y = 9'd100; iJump = 1'b1;
        @(negedge clk);
        iJump = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_frame(1, i == 3, dc, di);
            check("jump_y", 32'(current_topLeft_Y), 32'(exp_jump[i]));
            check("jump_air", 32'(oAirborne), 32'd1);
        end
        motion_en = 1'b0;
        xs = int'(current_topLeft_X);
        for (int i = 0; i < 4; i++) begin
            run_frame(2, 1'b0, dc, di);
            check("freeze_y", 32'(current_topLeft_Y), 32'd0);
            check("freeze_x", 32'(current_topLeft_X), 32'(xs));
            check("freeze_done", 32'(dc), 32'd1);
        end
        motion_en = 1'b1;
        for (int i = 5; i < 9; i++) begin
            run_frame(1, 1'b0, dc, di);
            check("resume_y", 32'(current_topLeft_Y), 32'(exp_jump[i]));
        end

        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_x", 32'(current_topLeft_X), 32'd100);
        check("midrst_y", 32'(current_topLeft_Y), 32'd40);
        check("midrst_air", 32'(oAirborne), 32'd0);
        check("midrst_done", 32'(oFrameDone), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_frame(5, 1'b0, dc, di);
        check("stall_done_count", 32'(dc), 32'd1);
        check("stall_x", 32'(current_topLeft_X), 32'd102);

        jump_rate = 10;
        for (int i = 0; i < 300; i++) begin
            motion_en = ($urandom_range(0, 99) >= 20);
            run_frame(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), dc, di);
            check("rand_done_count", 32'(dc), 32'd1);
        end

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
